// File: rtl/and2_share_arb_pkg.sv
// Shared definitions for the round-robin AND-sharing controller: default sizes,
// pointer wrap helper and the default-width response record.
package and2_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 1;
  localparam int ID_W_DEF  = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic                 valid;
    logic [ID_W_DEF-1:0]  id;
    logic [WIDTH_DEF-1:0] data;
  } rsp_rec_t;

  // Pointer moves just past the last winner, wrapping to 0 after the top index.
  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/and2_share_arb_if.sv
// Request/response bundle between the requesters/consumer (master) and the
// shared-AND controller (slave).
interface and2_share_arb_if
  import and2_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    // Valid/ready: a beat moves on a rising clk edge where valid and ready are
    // both high; the source holds valid and payload stable until that edge.
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/and2_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[IW'(idx)]) begin
                found              = 1'b1;
                grant[IW'(idx)]    = 1'b1;
                grant_idx          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/and2_share_arb.sv
// Shares one registered a&b unit among N_REQ requesters with round-robin grant
// and a single-entry tagged result register.
module and2_share_arb
  import and2_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    and2_share_arb_if.slave   bus,
    output logic [ID_W-1:0]   dbg_ptr
);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic [ID_W-1:0]  ptr;
    rsp_t             rsp_q;
    logic             busy_q;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             can_accept;
    logic             fire;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Reset gates ready so nothing looks accepted while the block is held in reset.
    assign can_accept    = !rsp_q.valid || bus.rsp_ready;
    assign bus.req_ready = grant & {N_REQ{can_accept & reset}};
    assign fire          = |bus.req_ready;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel = a_sel | ({WIDTH{grant[i]}} & bus.req_a[i*WIDTH +: WIDTH]);
            b_sel = b_sel | ({WIDTH{grant[i]}} & bus.req_b[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            rsp_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= rsp_q.valid | (|bus.req_valid);
            if (fire) begin
                rsp_q.valid <= 1'b1;
                rsp_q.id    <= grant_idx;
                rsp_q.data  <= a_sel & b_sel;
                ptr         <= ID_W'(next_ptr(int'(grant_idx), N_REQ));
            end else if (bus.rsp_ready) begin
                // Drain without refill keeps data/id for observability.
                rsp_q.valid <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.busy      = busy_q;
    assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_and2_share_arb.sv
// Bench for and2_share_arb: directed scenarios plus constrained-random traffic
// checked every cycle against a behavioural round-robin model.
module tb_and2_share_arb;
  import and2_pkg::*;

  localparam int NR = 4;
  localparam int W  = 4;
  localparam int IW = $clog2(NR);

  logic          clk;
  logic          reset;
  logic [IW-1:0] dbg_ptr;
  int            checks;
  int            failures;

  and2_share_arb_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  and2_share_arb #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .dbg_ptr (dbg_ptr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: expected contents of the result register and pointer
  int            m_ptr;
  bit            m_valid;
  logic [W-1:0]  m_data;
  int            m_id;
  bit            m_busy;
  logic [W-1:0]  exp_q[$];

  always @(negedge clk) begin
    logic [NR-1:0] er;
    int            g;
    int            j;
    bit            nb;
    if (!reset) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_id = 0; m_busy = 0;
      exp_q.delete();
    end
    er = '0;
    g  = -1;
    if (reset && !(m_valid && !bus.rsp_ready)) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (g < 0 && ((bus.req_valid >> j) & 1) != 0) g = j;
      end
    end
    if (g >= 0) er = NR'(1) << g;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    check("rsp_data",  32'(bus.rsp_data),  32'(m_data));
    check("rsp_id",    32'(bus.rsp_id),    m_id);
    check("busy",      32'(bus.busy),      32'(m_busy));
    check("ptr",       32'(dbg_ptr),       m_ptr);
    if (reset) begin
      if (m_valid && bus.rsp_ready && exp_q.size() > 0)
        check("consumed_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
      nb = m_valid || (bus.req_valid != '0);
      if (g >= 0) begin
        m_data  = W'(bus.req_a >> (g * W)) & W'(bus.req_b >> (g * W));
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % NR;
        exp_q.push_back(m_data);
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 0;
      end
      m_busy = nb;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input logic [NR-1:0] held);
    logic [NR-1:0]   nv;
    logic [NR*W-1:0] na;
    logic [NR*W-1:0] nbv;
    logic [NR*W-1:0] mask;
    nv  = bus.req_valid;
    na  = bus.req_a;
    nbv = bus.req_b;
    for (int i = 0; i < NR; i++) begin
      if (!held[i]) begin
        mask = (NR*W)'({W{1'b1}}) << (i * W);
        nv[i] = ($urandom_range(0, 2) == 0);
        na  = (na  & ~mask) | ((NR*W)'(W'($urandom)) << (i * W));
        nbv = (nbv & ~mask) | ((NR*W)'(W'($urandom)) << (i * W));
      end
    end
    bus.req_valid = nv;
    bus.req_a     = na;
    bus.req_b     = nbv;
    bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  int exp_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [NR-1:0] held;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    // reset with all requesters valid
    repeat (3) begin
      tick();
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
    end
    reset = 1'b1;
    bus.req_a = 16'h1111;
    bus.req_b = 16'h1111;
    bus.rsp_ready = 1'b1;
    #1;
    check("first_grant", 32'(bus.req_ready), 32'h1);

    // round robin at full throughput
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_id", 32'(bus.rsp_id), exp_ids[k]);
      check("rr_data", 32'(bus.rsp_data), 1);
      check("rr_valid", 32'(bus.rsp_valid), 1);
    end

    // backpressure for 5 cycles
    bus.rsp_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_id", 32'(bus.rsp_id), 0);
      check("bp_ptr", 32'(dbg_ptr), 1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(bus.req_ready), 32'h2);
    tick();
    check("bp_release_id", 32'(bus.rsp_id), 1);
    check("bp_release_ptr", 32'(dbg_ptr), 2);

    // drain, then single requester data check
    bus.req_valid = '0;
    tick();
    check("drain_valid", 32'(bus.rsp_valid), 0);
    bus.req_valid = 4'b0100;
    bus.req_a = 16'h0C00;
    bus.req_b = 16'h0A00;
    tick();
    check("data_c_and_a", 32'(bus.rsp_data), 32'h8);
    check("data_id", 32'(bus.rsp_id), 2);
    check("data_ptr", 32'(dbg_ptr), 3);

    // sparse request below the pointer
    bus.req_valid = '0;
    tick();
    check("idle_ptr", 32'(dbg_ptr), 3);
    bus.req_valid = 4'b0010;
    bus.req_a = 16'h00F0;
    bus.req_b = 16'h0030;
    #1;
    check("sparse_grant", 32'(bus.req_ready), 32'h2);
    tick();
    check("sparse_id", 32'(bus.rsp_id), 1);
    check("sparse_ptr", 32'(dbg_ptr), 2);
    check("sparse_data", 32'(bus.rsp_data), 3);

    // reset during a burst
    bus.req_valid = 4'b1111;
    tick();
    check("burst_valid", 32'(bus.rsp_valid), 1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.rsp_valid), 0);
    check("async_rst_ptr", 32'(dbg_ptr), 0);
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_grant", 32'(bus.req_ready), 32'h1);

    // random traffic honouring hold-until-accepted
    repeat (400) begin
      @(negedge clk);
      held = bus.req_valid & ~bus.req_ready;
      tick();
      drive_random(held);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
